// File: rtl/eth_tx_chan_arb.sv
`default_nettype none
// eth_tx_chan_arb: packet-granular round-robin scheduler over NUM_CH control/data FIFO pairs. Rev 1.0
// Optional per-channel packet/byte counters are enabled by defining ETH_TX_ARB_STATS_EN.
module eth_tx_chan_arb #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 14,
  parameter int IPG_CYC = 1,
  parameter int CH_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        pktc_valid,
  input  logic [NUM_CH*LEN_W-1:0]  pktc_len,
  output logic [NUM_CH-1:0]        pktc_ready,
  input  logic [NUM_CH-1:0]        pktd_valid,
  input  logic [NUM_CH*DATA_W-1:0] pktd_data,
  output logic [NUM_CH-1:0]        pktd_ready,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic [DATA_W/8-1:0]      tx_keep,
  output logic                     tx_sop,
  output logic                     tx_eop,
  output logic [CH_W-1:0]          tx_ch,
  output logic                     err_zero_len
`ifdef ETH_TX_ARB_STATS_EN
  ,
  input  logic [CH_W-1:0]          stat_sel,
  output logic [31:0]              stat_pkts,
  output logic [31:0]              stat_bytes
`endif
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_IPG_W = (IPG_CYC > 1) ? $clog2(IPG_CYC) : 1;
  localparam logic [c_IPG_W-1:0] c_IPG_LOAD = (IPG_CYC > 0) ? c_IPG_W'(IPG_CYC - 1) : '0;
  localparam logic [LEN_W-1:0]   c_BYTES_L  = LEN_W'(c_BYTES);
  localparam logic [CH_W-1:0]    c_LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CH_W-1:0]      r_last_grant;
  logic [CH_W-1:0]      r_ch;
  logic [LEN_W-1:0]     r_rem;
  logic                 r_sop;
  logic [c_IPG_W-1:0]   r_ipg;

  logic                 w_any;
  logic [CH_W-1:0]      w_gnt;
  logic [NUM_CH-1:0]    w_gnt_oh;
  logic [LEN_W-1:0]     w_gnt_len;
  int                   w_dist;
  int                   w_best;
  logic [NUM_CH-1:0]    w_ch_oh;
  logic [DATA_W-1:0]    w_data;
  logic                 w_dvalid;
  logic [c_BYTES-1:0]   w_keep;
  logic                 w_grant;
  logic                 w_beat;
  logic                 w_last;

  // Pick the requester closest (cyclically) to the slot after the last grant.
  always_comb begin
    w_any     = 1'b0;
    w_gnt     = '0;
    w_gnt_oh  = '0;
    w_gnt_len = '0;
    w_dist    = 0;
    w_best    = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dist = (i + NUM_CH - 1 - int'(r_last_grant)) % NUM_CH;
      if (pktc_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_any       = 1'b1;
        w_gnt       = CH_W'(i);
        w_gnt_oh    = '0;
        w_gnt_oh[i] = 1'b1;
        w_gnt_len   = pktc_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    w_ch_oh  = '0;
    w_data   = '0;
    w_dvalid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch_oh[i] = (CH_W'(i) == r_ch);
      if (CH_W'(i) == r_ch) begin
        w_data   = pktd_data[i*DATA_W +: DATA_W];
        w_dvalid = pktd_valid[i];
      end
    end
  end

  always_comb begin
    w_keep = '0;
    for (int b = 0; b < c_BYTES; b++) begin
      w_keep[b] = (LEN_W'(b) < r_rem);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    pktc_ready   = '0;
    pktd_ready   = '0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    tx_keep      = '0;
    tx_sop       = 1'b0;
    tx_eop       = 1'b0;
    err_zero_len = 1'b0;
    w_grant      = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so a held reset never pops a control FIFO.
        if (w_any && !reset) begin
          w_grant    = 1'b1;
          pktc_ready = w_gnt_oh;
          if (w_gnt_len == '0) begin
            err_zero_len = 1'b1;
          end else begin
            w_state_nxt = S_XFER;
          end
        end
      end
      S_XFER: begin
        tx_valid   = w_dvalid;
        tx_data    = w_data;
        tx_keep    = w_keep;
        tx_sop     = r_sop;
        w_last     = (r_rem <= c_BYTES_L);
        tx_eop     = w_last;
        pktd_ready = tx_ready ? w_ch_oh : '0;
        w_beat     = w_dvalid && tx_ready;
        if (w_beat && w_last) begin
          w_state_nxt = (IPG_CYC > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_ipg == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= c_LAST_CH;
      r_ch         <= '0;
      r_rem        <= '0;
      r_sop        <= 1'b0;
      r_ipg        <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_gnt;
        r_ch         <= w_gnt;
        r_rem        <= w_gnt_len;
        r_sop        <= 1'b1;
      end
      if (w_beat) begin
        r_rem <= (r_rem > c_BYTES_L) ? (r_rem - c_BYTES_L) : '0;
        r_sop <= 1'b0;
        if (w_last) begin
          r_ipg <= c_IPG_LOAD;
        end
      end
      if ((r_state == S_GAP) && (r_ipg != '0)) begin
        r_ipg <= r_ipg - c_IPG_W'(1);
      end
    end
  end

  assign tx_ch = r_ch;

`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0]      r_pkts  [NUM_CH];
  logic [31:0]      r_bytes [NUM_CH];
  logic [LEN_W-1:0] r_len_tot;

  // Byte count is credited with the descriptor length once the packet completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pkts[i]  <= '0;
        r_bytes[i] <= '0;
      end
      r_len_tot <= '0;
    end else begin
      if (w_grant) begin
        r_len_tot <= w_gnt_len;
      end
      if (w_beat && w_last) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_ch_oh[i]) begin
            r_pkts[i]  <= r_pkts[i] + 32'd1;
            r_bytes[i] <= r_bytes[i] + 32'(r_len_tot);
          end
        end
      end
    end
  end

  always_comb begin
    stat_pkts  = '0;
    stat_bytes = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == stat_sel) begin
        stat_pkts  = r_pkts[i];
        stat_bytes = r_bytes[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_chan_arb.sv
`default_nettype none
// tb_eth_tx_chan_arb: FIFO-model driver plus packet-level round-robin scoreboard.
module tb_eth_tx_chan_arb;

  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 64;
  localparam int LEN_W   = 14;
  localparam int IPG_CYC = 1;
  localparam int CH_W    = 3;
  localparam int BYTES   = DATA_W / 8;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        pktc_valid;
  logic [NUM_CH*LEN_W-1:0]  pktc_len;
  logic [NUM_CH-1:0]        pktc_ready;
  logic [NUM_CH-1:0]        pktd_valid;
  logic [NUM_CH*DATA_W-1:0] pktd_data;
  logic [NUM_CH-1:0]        pktd_ready;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [DATA_W-1:0]        tx_data;
  logic [BYTES-1:0]         tx_keep;
  logic                     tx_sop;
  logic                     tx_eop;
  logic [CH_W-1:0]          tx_ch;
  logic                     err_zero_len;

  eth_tx_chan_arb #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .IPG_CYC(IPG_CYC), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pktc_valid(pktc_valid), .pktc_len(pktc_len), .pktc_ready(pktc_ready),
    .pktd_valid(pktd_valid), .pktd_data(pktd_data), .pktd_ready(pktd_ready),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_keep(tx_keep),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ch(tx_ch), .err_zero_len(err_zero_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  keep;
    logic              sop;
    logic              eop;
    logic [CH_W-1:0]   ch;
  } beat_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            zero;
  } gnt_t;

  beat_t             exp_b[$];
  gnt_t              exp_g[$];
  int                cq[NUM_CH][$];
  logic [DATA_W-1:0] dq[NUM_CH][$];
  int                mp[NUM_CH][$];
  logic [DATA_W-1:0] md[NUM_CH][$];
  int                sp_len[7] = '{0, 1, 7, 8, 9, 16, 64};

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = NUM_CH - 1;
  int hs_cnt  = 0;
  int ready_mode = 1;
  bit bubble_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    int nb;
    logic [DATA_W-1:0] d;
    nb = (len + BYTES - 1) / BYTES;
    cq[ch].push_back(len);
    mp[ch].push_back(len);
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      dq[ch].push_back(d);
      md[ch].push_back(d);
    end
  endtask

  // Serve all pending packets in round-robin order starting after m_last.
  task automatic commit_round();
    int g, len, nb, r, c;
    beat_t e;
    gnt_t  q;
    while (1) begin
      g = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (g < 0 && mp[c].size() > 0) g = c;
      end
      if (g < 0) break;
      len    = mp[g].pop_front();
      m_last = g;
      q.ch   = CH_W'(g);
      q.zero = (len == 0);
      exp_g.push_back(q);
      nb = (len + BYTES - 1) / BYTES;
      for (int b = 0; b < nb; b++) begin
        r      = len - BYTES * (nb - 1);
        e.data = md[g].pop_front();
        e.sop  = (b == 0);
        e.eop  = (b == nb - 1);
        e.keep = (b < nb - 1) ? {BYTES{1'b1}} : BYTES'((1 << r) - 1);
        e.ch   = CH_W'(g);
        exp_b.push_back(e);
      end
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NUM_CH; i++) begin
      cq[i].delete(); dq[i].delete(); mp[i].delete(); md[i].delete();
    end
    exp_b.delete();
    exp_g.delete();
  endtask

  task automatic wait_drain();
    int cyc;
    bit busy;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 4000) begin
      @(posedge clk); #2;
      cyc++;
      busy = (exp_b.size() > 0) || (exp_g.size() > 0);
      for (int i = 0; i < NUM_CH; i++) busy |= (cq[i].size() > 0) || (dq[i].size() > 0);
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats and %0d grants still pending", exp_b.size(), exp_g.size());
      flush_all();
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string pre);
    chk({pre, "_tx_valid"}, 64'(tx_valid), 64'(0));
    chk({pre, "_pktc_ready"}, 64'(pktc_ready), 64'(0));
    chk({pre, "_pktd_ready"}, 64'(pktd_ready), 64'(0));
    chk({pre, "_tx_data"}, 64'(tx_data), 64'(0));
    chk({pre, "_tx_keep"}, 64'(tx_keep), 64'(0));
    chk({pre, "_tx_sop_eop"}, 64'({tx_sop, tx_eop}), 64'(0));
    chk({pre, "_tx_ch"}, 64'(tx_ch), 64'(0));
    chk({pre, "_err_zero_len"}, 64'(err_zero_len), 64'(0));
  endtask

  // FIFO model: pops sampled at negedge, applied and re-driven just after posedge.
  initial begin
    logic [NUM_CH-1:0] cap_c, cap_d, hold;
    forever begin
      @(negedge clk);
      cap_c = pktc_ready;
      cap_d = pktd_ready & pktd_valid;
      hold  = pktd_valid & ~cap_d;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_c[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        if (cap_d[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      end
      case (ready_mode)
        0:       tx_ready = 1'($urandom_range(0, 1));
        1:       tx_ready = 1'b1;
        default: tx_ready = ~tx_ready;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        pktc_valid[i] = (cq[i].size() > 0);
        pktc_len[i*LEN_W +: LEN_W] = (cq[i].size() > 0) ? LEN_W'(cq[i][0]) : '0;
        if (dq[i].size() > 0) begin
          pktd_data[i*DATA_W +: DATA_W] = dq[i][0];
          pktd_valid[i] = hold[i] || !bubble_en || ($urandom_range(0, 3) != 0);
        end else begin
          pktd_data[i*DATA_W +: DATA_W] = '0;
          pktd_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t             m_e;
    gnt_t              m_g;
    logic              prev_stall, prev_eop;
    logic [DATA_W-1:0] s_data;
    logic [BYTES-1:0]  s_keep;
    logic              s_sop, s_eop;
    prev_stall = 1'b0;
    prev_eop   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_eop   = 1'b0;
      end else begin
        if (prev_eop) begin
          chk("gap_tx_valid", 64'(tx_valid), 64'(0));
          chk("gap_pktc_ready", 64'(pktc_ready), 64'(0));
        end
        if (prev_stall) begin
          chk("stall_valid", 64'(tx_valid), 64'(1));
          chk("stall_data", 64'(tx_data), 64'(s_data));
          chk("stall_keep_sop_eop", 64'({tx_keep, tx_sop, tx_eop}), 64'({s_keep, s_sop, s_eop}));
        end
        if (pktc_ready != '0) begin
          if (exp_g.size() == 0) begin
            chk("unexpected_grant", 64'(pktc_ready), 64'(0));
          end else begin
            m_g = exp_g.pop_front();
            chk("grant_onehot", 64'(pktc_ready), 64'(1) << m_g.ch);
            chk("grant_err_zero_len", 64'(err_zero_len), 64'(m_g.zero));
            chk("grant_tx_valid", 64'(tx_valid), 64'(0));
          end
        end else if (err_zero_len) begin
          chk("err_without_grant", 64'(err_zero_len), 64'(0));
        end
        prev_eop   = 1'b0;
        prev_stall = 1'b0;
        if (tx_valid) begin
          if (exp_b.size() == 0) begin
            chk("unexpected_beat", 64'(tx_valid), 64'(0));
          end else begin
            m_e = exp_b[0];
            chk("pktd_ready", 64'(pktd_ready), tx_ready ? (64'(1) << m_e.ch) : 64'(0));
            if (tx_ready) begin
              void'(exp_b.pop_front());
              hs_cnt++;
              chk("beat_data", 64'(tx_data), 64'(m_e.data));
              chk("beat_keep", 64'(tx_keep), 64'(m_e.keep));
              chk("beat_sop", 64'(tx_sop), 64'(m_e.sop));
              chk("beat_eop", 64'(tx_eop), 64'(m_e.eop));
              chk("beat_tx_ch", 64'(tx_ch), 64'(m_e.ch));
              prev_eop = tx_eop;
            end else begin
              prev_stall = 1'b1;
              s_data = tx_data;
              s_keep = tx_keep;
              s_sop  = tx_sop;
              s_eop  = tx_eop;
            end
          end
        end
      end
    end
  end

  initial begin
    int h0, n, cyc;
    reset      = 1'b1;
    tx_ready   = 1'b1;
    pktc_valid = '0;
    pktc_len   = '0;
    pktd_valid = '0;
    pktd_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #2;

    // All channels with 64-byte packets, always ready: ch0,1,2,0,1,2.
    for (int rep = 0; rep < 2; rep++)
      for (int c = 0; c < NUM_CH; c++) add_pkt(c, 64);
    commit_round();
    wait_drain();

    // Zero-length, partial two-beat and single-beat packets, then resume at ch0.
    add_pkt(0, 0);
    add_pkt(1, 13);
    add_pkt(2, 5);
    commit_round();
    wait_drain();
    add_pkt(0, 24);
    commit_round();
    wait_drain();

    // Toggling tx_ready through a 64-byte packet.
    ready_mode = 2;
    h0 = hs_cnt;
    add_pkt(1, 64);
    commit_round();
    wait_drain();
    chk("toggle_beat_count", 64'(hs_cnt - h0), 64'(8));

    // Randomised rounds with data bubbles and random backpressure.
    ready_mode = 0;
    bubble_en  = 1'b1;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++)
          add_pkt(c, ($urandom_range(0, 3) == 0) ? sp_len[$urandom_range(0, 6)] : int'($urandom_range(1, 40)));
      end
      commit_round();
      wait_drain();
    end

    // Reset on the third beat of a 64-byte packet.
    ready_mode = 1;
    bubble_en  = 1'b0;
    @(posedge clk); #2;
    add_pkt(0, 64);
    add_pkt(1, 64);
    commit_round();
    h0  = hs_cnt;
    cyc = 0;
    while ((hs_cnt - h0) < 2 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("reset_test_two_beats", 64'(hs_cnt - h0), 64'(2));
    reset = 1'b1;
    @(posedge clk); #2;
    check_idle("midpkt_reset");
    flush_all();
    m_last = NUM_CH - 1;
    @(posedge clk); #2;
    reset = 1'b0;
    add_pkt(1, 16);
    add_pkt(0, 16);
    commit_round();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
